// File: rtl/lcd_8080_writer.sv
`default_nettype none
// lcd_8080_writer: FIFO-buffered 8080-style panel write sequencer with panel reset sequencing.
// Revision 1.0 - initial release.
module lcd_8080_writer #(
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int WR_LOW       = 2,
  parameter int WR_HIGH      = 2,
  parameter int RST_LOW_CYC  = 500,
  parameter int RST_WAIT_CYC = 6000,
  parameter int CS_IDLE_CYC  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_dc,
  input  logic                        s_last,
  input  logic                        init_req,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        lcd_csx,
  output logic                        lcd_dcx,
  output logic                        lcd_wrx,
  output logic                        lcd_rdx,
  output logic                        lcd_reset,
  output logic [DATA_W-1:0]           lcd_data
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int EW      = DATA_W + 2;
  localparam int MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_B   = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CNT = (MAX_C > CS_IDLE_CYC) ? MAX_C : CS_IDLE_CYC;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] RL_END   = CW'(RST_LOW_CYC - 1);
  localparam logic [CW-1:0] RW_END   = CW'(RST_WAIT_CYC - 1);
  localparam logic [CW-1:0] WL_END   = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] WH_END   = CW'(WR_HIGH - 1);
  localparam logic [CW-1:0] CI_END   = CW'(CS_IDLE_CYC - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_RST_LOW  = 3'd0,
    S_RST_WAIT = 3'd1,
    S_IDLE     = 3'd2,
    S_SETUP    = 3'd3,
    S_WR_LO    = 3'd4,
    S_WR_HI    = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          init_pend;
  logic          cur_last;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          hi_done;
  logic          init_hold;

  assign full       = (count == FULL_LVL);
  assign empty      = (count == '0);
  assign s_ready    = reset_n & ~full;
  assign push       = s_valid & s_ready;
  assign head       = mem[rd_ptr];
  assign hi_done    = (state == S_WR_HI) && (cnt == WH_END);
  assign init_hold  = init_pend | init_req;
  // Pop exactly where the FSM loads a new word into SETUP.
  assign pop        = ~empty & (((state == S_IDLE) & ~init_req) |
                                (hi_done & ~init_hold & ~cur_last));
  assign busy       = (state != S_IDLE) | ~empty;
  assign fifo_level = count;
  assign lcd_rdx    = 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_dc, s_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RST_LOW;
      cnt       <= '0;
      init_pend <= 1'b0;
      cur_last  <= 1'b0;
      lcd_reset <= 1'b0;
      lcd_csx   <= 1'b1;
      lcd_wrx   <= 1'b1;
      lcd_dcx   <= 1'b1;
      lcd_data  <= '0;
    end else begin
      if (init_req && (state == S_SETUP || state == S_WR_LO || state == S_WR_HI))
        init_pend <= 1'b1;
      case (state)
        S_RST_LOW: begin
          if (cnt == RL_END) begin
            state     <= S_RST_WAIT;
            cnt       <= '0;
            lcd_reset <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RST_WAIT: begin
          if (cnt == RW_END) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (init_req) begin
            state     <= S_RST_LOW;
            cnt       <= '0;
            lcd_reset <= 1'b0;
            lcd_csx   <= 1'b1;
          end else if (!empty) begin
            state    <= S_SETUP;
            lcd_csx  <= 1'b0;
            lcd_dcx  <= head[DATA_W];
            lcd_data <= head[DATA_W-1:0];
            cur_last <= head[DATA_W+1];
          end else if (!lcd_csx) begin
            // Close an open frame once the producer has gone quiet.
            if (cnt == CI_END) begin
              lcd_csx <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_SETUP: begin
          state   <= S_WR_LO;
          cnt     <= '0;
          lcd_wrx <= 1'b0;
        end
        S_WR_LO: begin
          if (cnt == WL_END) begin
            state   <= S_WR_HI;
            cnt     <= '0;
            lcd_wrx <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_HI: begin
          if (cnt == WH_END) begin
            cnt <= '0;
            if (init_hold) begin
              state     <= S_RST_LOW;
              init_pend <= 1'b0;
              lcd_reset <= 1'b0;
              lcd_csx   <= 1'b1;
            end else if (cur_last) begin
              state   <= S_IDLE;
              lcd_csx <= 1'b1;
            end else if (!empty) begin
              state    <= S_SETUP;
              lcd_dcx  <= head[DATA_W];
              lcd_data <= head[DATA_W-1:0];
              cur_last <= head[DATA_W+1];
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_RST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_8080_writer.sv
`default_nettype none
// tb_lcd_8080_writer: randomized self-checking bench; a pin monitor decodes panel writes
// and each scenario task compares them against a queue of pushed words and timing rules.
module tb_lcd_8080_writer;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int WL     = 2;
  localparam int WH     = 2;
  localparam int RL     = 4;
  localparam int RW     = 6;
  localparam int CI     = 8;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int PERIOD = 1 + WL + WH;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          s_valid  = 1'b0;
  logic          s_dc     = 1'b0;
  logic          s_last   = 1'b0;
  logic          init_req = 1'b0;
  logic [DW-1:0] s_data   = '0;
  logic          s_ready, busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_reset;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { logic dc; logic [DW-1:0] data; logic last; } word_t;
  typedef struct { logic dc; logic [DW-1:0] data; int low; int rise; bit ok; } wr_t;
  word_t exp_q[$];
  wr_t   obs_q[$];

  int csx_fall_cyc = -1;
  int csx_rise_cyc = -1;
  int csx_rises    = 0;
  int rst_fall_cyc = -1;
  int rst_rise_cyc = -1;

  lcd_8080_writer #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WR_LOW(WL), .WR_HIGH(WH),
    .RST_LOW_CYC(RL), .RST_WAIT_CYC(RW), .CS_IDLE_CYC(CI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_dc(s_dc), .s_last(s_last), .init_req(init_req),
    .busy(busy), .fifo_level(fifo_level), .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx),
    .lcd_wrx(lcd_wrx), .lcd_rdx(lcd_rdx), .lcd_reset(lcd_reset), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: one record per wrx rising edge, sampled on the falling clock edge.
  logic          p_wrx = 1'b1;
  logic          p_csx = 1'b1;
  logic          p_rst = 1'b0;
  logic [DW-1:0] lo_data = '0;
  logic          lo_dc = 1'b0;
  int            low_cnt = 0;
  bit            lo_ok = 1'b1;
  always @(negedge clk) begin
    if (!reset_n) begin
      p_wrx   = 1'b1;
      p_csx   = 1'b1;
      p_rst   = 1'b0;
      low_cnt = 0;
    end else begin
      if (lcd_wrx === 1'b0) begin
        if (p_wrx === 1'b1) begin
          lo_data = lcd_data;
          lo_dc   = lcd_dcx;
          lo_ok   = (lcd_csx === 1'b0) && (p_csx === 1'b0);
          low_cnt = 0;
        end
        low_cnt++;
        if (lcd_csx !== 1'b0 || lcd_data !== lo_data || lcd_dcx !== lo_dc) lo_ok = 1'b0;
      end else if (p_wrx === 1'b0) begin
        obs_q.push_back('{dc: lcd_dcx, data: lcd_data, low: low_cnt, rise: cyc,
                          ok: lo_ok && (lcd_csx === 1'b0) && (lcd_data === lo_data) && (lcd_dcx === lo_dc)});
      end
      if (lcd_csx === 1'b0 && p_csx === 1'b1) csx_fall_cyc = cyc;
      if (lcd_csx === 1'b1 && p_csx === 1'b0) begin
        csx_rise_cyc = cyc;
        csx_rises++;
      end
      if (lcd_reset === 1'b0 && p_rst === 1'b1) rst_fall_cyc = cyc;
      if (lcd_reset === 1'b1 && p_rst === 1'b0) rst_rise_cyc = cyc;
      p_wrx = lcd_wrx;
      p_csx = lcd_csx;
      p_rst = lcd_reset;
    end
  end

  task automatic wait_obs(input int n, input int budget, output bit to);
    int t = 0;
    while (obs_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    to = (obs_q.size() < n);
  endtask

  task automatic push_word(input logic dc, input logic [DW-1:0] d, input logic last, output bit to);
    int t = 0;
    s_valid = 1'b1; s_dc = dc; s_data = d; s_last = last;
    while (!s_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    to = !s_ready;
    if (!to) begin
      exp_q.push_back('{dc: dc, data: d, last: last});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_wrx_low(output bit to);
    int t = 0;
    while (lcd_wrx !== 1'b0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    to = (lcd_wrx !== 1'b0);
  endtask

  task automatic test_reset();
    int c0; bit to; word_t e; wr_t o;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (lcd_reset !== 1'b0) begin errors++; $display("FAIL rst_lcd_reset got %b want 0", lcd_reset); end
    checks++; if (lcd_csx !== 1'b1) begin errors++; $display("FAIL rst_csx got %b want 1", lcd_csx); end
    checks++; if (lcd_wrx !== 1'b1 || lcd_rdx !== 1'b1) begin errors++; $display("FAIL rst_wrx_rdx got %b%b want 11", lcd_wrx, lcd_rdx); end
    checks++; if (lcd_dcx !== 1'b1 || lcd_data !== '0) begin errors++; $display("FAIL rst_dcx_data got %b %h want 1 0000", lcd_dcx, lcd_data); end
    checks++; if (s_ready !== 1'b0 || busy !== 1'b1 || fifo_level !== '0) begin
      errors++; $display("FAIL rst_flow got ready=%b busy=%b level=%0d want 0 1 0", s_ready, busy, fifo_level); end
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    s_valid = 1'b1; s_dc = 1'b0; s_data = DW'($urandom); s_last = 1'b1;
    exp_q.push_back('{dc: 1'b0, data: s_data, last: 1'b1});
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_obs(1, 100, to);
    repeat (WH + 3) @(posedge clk);
    #1;
    checks++; if (to) begin errors++; $display("FAIL rst_first_write got timeout want write"); end
    checks++; if (rst_rise_cyc - c0 != RL) begin errors++; $display("FAIL rst_low_len got %0d want %0d", rst_rise_cyc - c0, RL); end
    checks++; if (csx_fall_cyc - c0 < RL + RW + 1) begin
      errors++; $display("FAIL rst_first_csx got %0d want >=%0d", csx_fall_cyc - c0, RL + RW + 1); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.dc !== e.dc || o.data !== e.data || o.low != WL || !o.ok) begin
        errors++; $display("FAIL rst_word got dc=%b data=%h low=%0d ok=%0d want dc=%b data=%h low=%0d", o.dc, o.data, o.low, o.ok, e.dc, e.data, WL);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_burst();
    bit to; bit any_to = 1'b0; int r0; int r[3]; int i = 0; word_t e; wr_t o;
    r0 = csx_rises;
    push_word(1'b0, 16'h002C, 1'b0, to); any_to |= to;
    push_word(1'b1, 16'h1234, 1'b0, to); any_to |= to;
    push_word(1'b1, 16'hABCD, 1'b1, to); any_to |= to;
    wait_obs(3, 100, to); any_to |= to;
    repeat (WH + 4) @(posedge clk);
    #1;
    checks++; if (any_to) begin errors++; $display("FAIL burst_progress got timeout want 3 writes"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL burst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (i < 3) r[i] = o.rise;
      i++;
      checks++;
      if (o.dc !== e.dc || o.data !== e.data || o.low != WL || !o.ok) begin
        errors++; $display("FAIL burst_word got dc=%b data=%h low=%0d ok=%0d want dc=%b data=%h low=%0d", o.dc, o.data, o.low, o.ok, e.dc, e.data, WL);
      end
    end
    checks++; if (r[1] - r[0] != PERIOD || r[2] - r[1] != PERIOD) begin
      errors++; $display("FAIL burst_spacing got %0d,%0d want %0d", r[1] - r[0], r[2] - r[1], PERIOD); end
    checks++; if (csx_rises - r0 != 1 || csx_rise_cyc != r[2] + WH) begin
      errors++; $display("FAIL burst_csx got rises=%0d at %0d want 1 at %0d", csx_rises - r0, csx_rise_cyc, r[2] + WH); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_cs_idle();
    bit to; bit any_to = 1'b0; int r0; int rise = 0; word_t e; wr_t o;
    r0 = csx_rises;
    push_word(1'($urandom_range(1)), DW'($urandom), 1'b0, to); any_to |= to;
    wait_obs(1, 100, to); any_to |= to;
    repeat (WH + CI + 5) @(posedge clk);
    #1;
    checks++; if (any_to) begin errors++; $display("FAIL idle_progress got timeout want 1 write"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL idle_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      rise = o.rise;
      checks++;
      if (o.dc !== e.dc || o.data !== e.data || o.low != WL || !o.ok) begin
        errors++; $display("FAIL idle_word got dc=%b data=%h low=%0d ok=%0d want dc=%b data=%h", o.dc, o.data, o.low, o.ok, e.dc, e.data);
      end
    end
    checks++; if (csx_rises - r0 != 1 || csx_rise_cyc != rise + WH + CI) begin
      errors++; $display("FAIL idle_csx got rises=%0d at %0d want 1 at %0d", csx_rises - r0, csx_rise_cyc, rise + WH + CI); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fill();
    int n = 0; int t = 0; bit have = 1'b0; bit saw_full = 1'b0; bit to; word_t e; wr_t o;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    while (n < DEPTH + 4 && t < 400) begin
      if (!have) begin
        s_dc = 1'($urandom_range(1)); s_data = DW'($urandom);
        s_last = ($urandom_range(3) == 0); s_valid = 1'b1; have = 1'b1;
      end
      checks++;
      if (s_ready !== (fifo_level != FULL_LVL)) begin
        errors++; $display("FAIL fill_ready got ready=%b level=%0d want ready=%b", s_ready, fifo_level, fifo_level != FULL_LVL);
      end
      if (fifo_level == FULL_LVL) saw_full = 1'b1;
      if (s_ready) begin
        exp_q.push_back('{dc: s_dc, data: s_data, last: s_last});
        have = 1'b0;
        n++;
      end
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    wait_obs(DEPTH + 4, 300, to);
    repeat (WH + CI + 5) @(posedge clk);
    #1;
    checks++; if (!saw_full) begin errors++; $display("FAIL fill_full got no full level want level=%0d", DEPTH); end
    checks++; if (to) begin errors++; $display("FAIL fill_progress got %0d writes want %0d", obs_q.size(), DEPTH + 4); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.dc !== e.dc || o.data !== e.data || o.low != WL || !o.ok) begin
        errors++; $display("FAIL fill_word got dc=%b data=%h low=%0d ok=%0d want dc=%b data=%h", o.dc, o.data, o.low, o.ok, e.dc, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_init_mid();
    bit to; bit any_to = 1'b0; int r1 = 0; int r2 = 0; int i = 0; word_t e; wr_t o;
    push_word(1'b0, DW'($urandom), 1'b0, to); any_to |= to;
    push_word(1'b1, DW'($urandom), 1'b0, to); any_to |= to;
    push_word(1'b1, DW'($urandom), 1'b1, to); any_to |= to;
    wait_wrx_low(to); any_to |= to;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    wait_obs(1, 50, to); any_to |= to;
    if (obs_q.size() > 0) r1 = obs_q[0].rise;
    repeat (WH + 1) @(posedge clk);
    #1;
    checks++; if (lcd_csx !== 1'b1 || lcd_reset !== 1'b0 || rst_fall_cyc != r1 + WH || csx_rise_cyc != r1 + WH) begin
      errors++; $display("FAIL init_enter got csx=%b rst=%b fall=%0d csxrise=%0d want 1 0 %0d %0d", lcd_csx, lcd_reset, rst_fall_cyc, csx_rise_cyc, r1 + WH, r1 + WH);
    end
    wait_obs(3, 200, to); any_to |= to;
    repeat (WH + 4) @(posedge clk);
    #1;
    checks++; if (any_to) begin errors++; $display("FAIL init_progress got timeout want 3 writes"); end
    checks++; if (rst_rise_cyc - rst_fall_cyc != RL) begin errors++; $display("FAIL init_rst_len got %0d want %0d", rst_rise_cyc - rst_fall_cyc, RL); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL init_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (i == 1) r2 = o.rise;
      i++;
      checks++;
      if (o.dc !== e.dc || o.data !== e.data || o.low != WL || !o.ok) begin
        errors++; $display("FAIL init_word got dc=%b data=%h low=%0d ok=%0d want dc=%b data=%h", o.dc, o.data, o.low, o.ok, e.dc, e.data);
      end
    end
    checks++; if (r2 != r1 + WH + RL + RW + 2 + WL) begin
      errors++; $display("FAIL init_resume got %0d want %0d", r2, r1 + WH + RL + RW + 2 + WL); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    bit to; bit any_to = 1'b0; int c0; word_t e; wr_t o;
    push_word(1'b0, DW'($urandom), 1'b0, to); any_to |= to;
    push_word(1'b1, DW'($urandom), 1'b0, to); any_to |= to;
    push_word(1'b1, DW'($urandom), 1'b1, to); any_to |= to;
    wait_wrx_low(to); any_to |= to;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({lcd_reset, lcd_csx, lcd_wrx, lcd_rdx, lcd_dcx, s_ready, busy} !== 7'b0111101 || lcd_data !== '0 || fifo_level !== '0) begin
      errors++; $display("FAIL areset_pins got rst=%b csx=%b wrx=%b rdx=%b dcx=%b rdy=%b busy=%b data=%h lvl=%0d want 0 1 1 1 1 0 1 0000 0",
        lcd_reset, lcd_csx, lcd_wrx, lcd_rdx, lcd_dcx, s_ready, busy, lcd_data, fifo_level);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    repeat (RL + RW + 20) @(posedge clk);
    #1;
    checks++; if (any_to) begin errors++; $display("FAIL areset_setup got timeout want word in flight"); end
    checks++; if (rst_rise_cyc - c0 != RL) begin errors++; $display("FAIL areset_rst_len got %0d want %0d", rst_rise_cyc - c0, RL); end
    checks++; if (obs_q.size() != 0 || lcd_csx !== 1'b1 || fifo_level !== '0) begin
      errors++; $display("FAIL areset_flushed got writes=%0d csx=%b lvl=%0d want 0 1 0", obs_q.size(), lcd_csx, fifo_level); end
    obs_q.delete();
    push_word(1'b1, DW'($urandom), 1'b1, to);
    wait_obs(1, 100, to);
    checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL areset_resume got %0d writes want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.dc !== e.dc || o.data !== e.data || o.low != WL || !o.ok) begin
        errors++; $display("FAIL areset_word got dc=%b data=%h ok=%0d want dc=%b data=%h", o.dc, o.data, o.ok, e.dc, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_cs_idle();
    test_fill();
    test_init_mid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
